operand_demux: RTL

Keypad-side operand entry router for the calculator datapath. It takes the single stream of 4-bit key codes from the keypad scanner and steers digits into one of two BCD operand registers, A or B, under a small entry state machine. It latches the operator between them and presents both operands plus the operator to the ALU/display path with a ready/ack handshake. Its `sel` output drives the downstream 2:1 display mux select: 1 shows A, 0 shows B.

---
 rtl/operand_demux.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/operand_demux.sv
// Keypad operand router: steers BCD digits into A or B, latches the operator, presents both with ready/ack.
// Latency: a key sampled at edge N is visible after edge N; all outputs are registered.
// Optional KEY_REPEAT_FILTER_EN: act only on the rising edge of key_valid so a held key counts once.
module operand_demux #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                ack,
  output logic [4*DIGITS-1:0] opa,
  output logic [4*DIGITS-1:0] opb,
  output logic [1:0]          op,
  output logic                sel,
  output logic                ready,
  output logic                overflow
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
  logic [W-1:0]  opa_nxt, opb_nxt;
  logic [1:0]    op_nxt;
  logic          sel_nxt, ready_nxt, overflow_nxt;
  logic          key;
  logic          is_digit, is_oper, is_eq, is_clr;

`ifdef KEY_REPEAT_FILTER_EN
  logic key_valid_q;

  // Remember last cycle's strobe so only its rising edge counts as a key.
  always_ff @(posedge clk) begin
    if (!rst_n) key_valid_q <= 1'b0;
    else        key_valid_q <= key_valid;
  end

  assign key = key_valid & ~key_valid_q;
`else
  assign key = key_valid;
`endif

  assign is_digit = key && (key_code <= 4'd9);
  assign is_oper  = key && (key_code >= 4'hA) && (key_code <= 4'hD);
  assign is_eq    = key && (key_code == 4'hE);
  assign is_clr   = key && (key_code == 4'hF);

  // Next-state and next-output decode; clear has priority over every state action.
  always_comb begin
    state_nxt    = state;
    cnt_a_nxt    = cnt_a;
    cnt_b_nxt    = cnt_b;
    opa_nxt      = opa;
    opb_nxt      = opb;
    op_nxt       = op;
    sel_nxt      = sel;
    ready_nxt    = ready;
    overflow_nxt = overflow;
    if (is_clr) begin
      state_nxt    = ENTER_A;
      cnt_a_nxt    = '0;
      cnt_b_nxt    = '0;
      opa_nxt      = '0;
      opb_nxt      = '0;
      op_nxt       = 2'd0;
      sel_nxt      = 1'b1;
      ready_nxt    = 1'b0;
      overflow_nxt = 1'b0;
    end else begin
      case (state)
        ENTER_A: begin
          if (is_digit) begin
            if (cnt_a != FULL) begin
              opa_nxt   = (opa << 4) | W'(key_code);
              cnt_a_nxt = cnt_a + CW'(1);
            end else begin
              overflow_nxt = 1'b1;
            end
          end else if (is_oper) begin
            op_nxt    = 2'(key_code - 4'hA);
            state_nxt = ENTER_B;
            sel_nxt   = 1'b0;
          end
        end
        ENTER_B: begin
          if (is_digit) begin
            if (cnt_b != FULL) begin
              opb_nxt   = (opb << 4) | W'(key_code);
              cnt_b_nxt = cnt_b + CW'(1);
            end else begin
              overflow_nxt = 1'b1;
            end
          end else if (is_oper) begin
            // Operator may be changed only until the first B digit arrives.
            if (cnt_b == '0) op_nxt = 2'(key_code - 4'hA);
          end else if (is_eq) begin
            state_nxt = DONE;
            ready_nxt = 1'b1;
          end
        end
        DONE: begin
          // Operator and sticky overflow survive the handshake.
          if (ack) begin
            state_nxt = ENTER_A;
            cnt_a_nxt = '0;
            cnt_b_nxt = '0;
            opa_nxt   = '0;
            opb_nxt   = '0;
            ready_nxt = 1'b0;
            sel_nxt   = 1'b1;
          end
        end
        default: begin
          state_nxt = ENTER_A;
          sel_nxt   = 1'b1;
          ready_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ENTER_A;
      cnt_a    <= '0;
      cnt_b    <= '0;
      opa      <= '0;
      opb      <= '0;
      op       <= 2'd0;
      sel      <= 1'b1;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_a    <= cnt_a_nxt;
      cnt_b    <= cnt_b_nxt;
      opa      <= opa_nxt;
      opb      <= opb_nxt;
      op       <= op_nxt;
      sel      <= sel_nxt;
      ready    <= ready_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule
